jump_target_table: RTL and testbench

- Parametrised, runtime-loadable successor to the fixed jump lookup table.
- Holds DEPTH branch-target entries, each with a valid bit.
- Loaded by a streaming ready/valid burst port and cleared by a one-entry-per-cycle sweep.
- Serves single-cycle registered lookups to the fetch/PC-next logic.

---
 rtl/jump_table_pkg.sv | 13 +
 rtl/jump_table_ptr.sv | 30 +++
 rtl/jump_target_table.sv | 168 ++++++++++++++++
 tb/tb_jump_target_table.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_table_pkg.sv
// Shared types and default sizing for the jump target table and the fetch unit.
package jump_table_pkg;

  localparam int DEFAULT_DEPTH = 64;
  localparam int DEFAULT_TW    = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2
  } state_t;

endpackage

// File: rtl/jump_table_ptr.sv
// Wrapping entry-index counter shared by the load burst and the clear sweep.
// Wraps from DEPTH-1 to 0 by explicit compare, so DEPTH need not be a power of two.
module jump_table_ptr #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  output logic [AW-1:0] ptr,
  output logic          at_last
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  assign at_last = (ptr == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= at_last ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/jump_target_table.sv
// Runtime-loadable branch target table with registered single-cycle lookups.
// Optional same-cycle write-to-lookup forwarding: define JUMP_TABLE_BYPASS_EN.
module jump_target_table
  import jump_table_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int TW    = DEFAULT_TW,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lk_req,
  input  logic [AW-1:0] lk_addr,
  output logic          lk_vld,
  output logic [TW-1:0] lk_target,
  output logic          lk_hit,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic [AW:0]   ld_count,
  input  logic          ld_valid,
  input  logic [TW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          clr_start,
  output logic          busy,
  output logic          done
);

  state_t        state, state_next;
  logic [AW-1:0] ptr;
  logic          at_last;
  logic          ptr_load;
  logic [AW-1:0] ptr_load_val;
  logic          ptr_inc;
  logic          done_next;
  logic [AW:0]   remaining;
  logic          beat;

  logic [TW-1:0] entries [DEPTH];
  logic [DEPTH-1:0] valid;

  logic          in_range;
  logic          rd_hit;
  logic [TW-1:0] rd_target;

  assign ld_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign beat     = ld_ready && ld_valid;

  jump_table_ptr #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (ptr_load),
    .load_val (ptr_load_val),
    .inc      (ptr_inc),
    .ptr      (ptr),
    .at_last  (at_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  // A clear request outranks a simultaneous load request, which is dropped.
  always_comb begin
    state_next   = state;
    ptr_load     = 1'b0;
    ptr_load_val = ld_base;
    ptr_inc      = 1'b0;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_next   = CLEAR;
          ptr_load     = 1'b1;
          ptr_load_val = '0;
        end else if (ld_start) begin
          if (ld_count == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = LOAD;
            ptr_load   = 1'b1;
          end
        end
      end
      LOAD: begin
        if (ld_valid) begin
          ptr_inc = 1'b1;
          if (remaining == (AW+1)'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      CLEAR: begin
        ptr_inc = 1'b1;
        if (at_last) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
    end else if (state == IDLE && ld_start && !clr_start) begin
      remaining <= ld_count;
    end else if (beat) begin
      remaining <= remaining - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      valid <= '0;
    end else if (beat) begin
      entries[ptr] <= ld_data;
      valid[ptr]   <= 1'b1;
    end else if (state == CLEAR) begin
      entries[ptr] <= '0;
      valid[ptr]   <= 1'b0;
    end
  end

  // Out-of-range indices (non-power-of-two DEPTH) and sweeps in progress read as misses.
  always_comb begin
    in_range  = ({1'b0, lk_addr} < (AW+1)'(DEPTH));
    rd_hit    = 1'b0;
    rd_target = '0;
    if (in_range && state != CLEAR && valid[lk_addr]) begin
      rd_hit    = 1'b1;
      rd_target = entries[lk_addr];
    end
`ifdef JUMP_TABLE_BYPASS_EN
    if (beat && ptr == lk_addr) begin
      rd_hit    = 1'b1;
      rd_target = ld_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lk_vld    <= 1'b0;
      lk_hit    <= 1'b0;
      lk_target <= '0;
    end else begin
      lk_vld    <= lk_req;
      lk_hit    <= lk_req && rd_hit;
      lk_target <= lk_req ? rd_target : '0;
    end
  end

endmodule

// File: tb/tb_jump_target_table.sv
// Directed self-checking bench for jump_target_table at DEPTH=64, TW=6.
module tb_jump_target_table;

  localparam int DEPTH = 64;
  localparam int TW    = 6;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          lk_req;
  logic [AW-1:0] lk_addr;
  logic          lk_vld;
  logic [TW-1:0] lk_target;
  logic          lk_hit;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW:0]   ld_count;
  logic          ld_valid;
  logic [TW-1:0] ld_data;
  logic          ld_ready;
  logic          clr_start;
  logic          busy;
  logic          done;

  int compared   = 0;
  int mismatched = 0;

  jump_target_table #(
    .DEPTH (DEPTH),
    .TW    (TW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .lk_req    (lk_req),
    .lk_addr   (lk_addr),
    .lk_vld    (lk_vld),
    .lk_target (lk_target),
    .lk_hit    (lk_hit),
    .ld_start  (ld_start),
    .ld_base   (ld_base),
    .ld_count  (ld_count),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .clr_start (clr_start),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Issue a single lookup and check the registered result one cycle later.
  task automatic lookupCheck(input string tag, input logic [AW-1:0] addr,
                             input logic exp_hit, input logic [TW-1:0] exp_target);
    lk_req  = 1'b1;
    lk_addr = addr;
    applyStimulus();
    lk_req = 1'b0;
    checkOutput({tag, "_vld"}, 32'(lk_vld), 32'd1);
    checkOutput({tag, "_hit"}, 32'(lk_hit), 32'(exp_hit));
    checkOutput({tag, "_target"}, 32'(lk_target), 32'(exp_target));
  endtask

  initial begin
    logic [AW-1:0] addrs [4];
    logic [TW-1:0] datas [4];
    int accepted;
    int busy_cycles;
    int done_pulses;

    reset = 1'b1; lk_req = 1'b0; lk_addr = '0;
    ld_start = 1'b0; ld_base = '0; ld_count = '0; ld_valid = 1'b0; ld_data = '0;
    clr_start = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_ready", 32'(ld_ready), 32'd0);
    checkOutput("rst_lkvld", 32'(lk_vld), 32'd0);
    checkOutput("rst_lkhit", 32'(lk_hit), 32'd0);
    checkOutput("rst_lktarget", 32'(lk_target), 32'd0);
    reset = 1'b0;
    applyStimulus();

    $display("[TB] lookup after reset");
    lookupCheck("lk_rst5", 6'd5, 1'b0, 6'd0);
    applyStimulus();
    checkOutput("lk_idle_vld", 32'(lk_vld), 32'd0);

    $display("[TB] wrapping load base 62 count 4");
    ld_start = 1'b1; ld_base = 6'd62; ld_count = 7'd4;
    applyStimulus();
    ld_start = 1'b0;
    checkOutput("ld1_busy0", 32'(busy), 32'd1);
    checkOutput("ld1_ready0", 32'(ld_ready), 32'd1);
    done_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data  = TW'(11 + i);
      applyStimulus();
      if (done) done_pulses++;
      checkOutput($sformatf("ld1_busy_beat%0d", i), 32'(busy), (i < 3) ? 32'd1 : 32'd0);
    end
    ld_valid = 1'b0;
    applyStimulus();
    if (done) done_pulses++;
    checkOutput("ld1_done_pulses", 32'(done_pulses), 32'd1);
    addrs = '{6'd62, 6'd63, 6'd0, 6'd1};
    datas = '{6'd11, 6'd12, 6'd13, 6'd14};
    lk_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lk_addr = addrs[i];
      applyStimulus();
      checkOutput($sformatf("ld1_hit_%0d", addrs[i]), 32'(lk_hit), 32'd1);
      checkOutput($sformatf("ld1_target_%0d", addrs[i]), 32'(lk_target), 32'(datas[i]));
    end
    lk_req = 1'b0;
    lookupCheck("ld1_miss2", 6'd2, 1'b0, 6'd0);

    $display("[TB] stalled load base 10");
    ld_start = 1'b1; ld_base = 6'd10; ld_count = 7'd4;
    applyStimulus();
    ld_start = 1'b0;
    accepted = 0;
    for (int c = 0; c < 8; c++) begin
      ld_valid = (c % 2) == 1;
      ld_data  = ld_valid ? TW'(21 + accepted) : 6'd55;
      checkOutput($sformatf("ld2_ready_c%0d", c), 32'(ld_ready), 32'd1);
      applyStimulus();
      if (ld_valid) accepted++;
      checkOutput($sformatf("ld2_done_c%0d", c), 32'(done), (c == 7) ? 32'd1 : 32'd0);
    end
    ld_valid = 1'b0;
    checkOutput("ld2_ready_after", 32'(ld_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      lookupCheck($sformatf("ld2_e%0d", 10 + i), AW'(10 + i), 1'b1, TW'(21 + i));
    end
    lookupCheck("ld2_miss14", 6'd14, 1'b0, 6'd0);

    $display("[TB] clear sweep");
    clr_start = 1'b1;
    applyStimulus();
    clr_start = 1'b0;
    busy_cycles = 0;
    done_pulses = 0;
    for (int i = 0; i < 80; i++) begin
      if (busy) busy_cycles++;
      if (done) done_pulses++;
      if (i == 21) begin
        checkOutput("clr_mid_vld", 32'(lk_vld), 32'd1);
        checkOutput("clr_mid_hit", 32'(lk_hit), 32'd0);
        checkOutput("clr_mid_target", 32'(lk_target), 32'd0);
        lk_req = 1'b0;
      end
      if (i == 20) begin
        lk_req  = 1'b1;
        lk_addr = 6'd62;
      end
      applyStimulus();
    end
    checkOutput("clr_busy_cycles", 32'(busy_cycles), 32'd64);
    checkOutput("clr_done_pulses", 32'(done_pulses), 32'd1);
    lookupCheck("clr_after62", 6'd62, 1'b0, 6'd0);
    lookupCheck("clr_after12", 6'd12, 1'b0, 6'd0);

    $display("[TB] same-cycle write and lookup at 7");
    ld_start = 1'b1; ld_base = 6'd7; ld_count = 7'd1;
    applyStimulus();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 6'd33;
    lk_req = 1'b1; lk_addr = 6'd7;
    applyStimulus();
    ld_valid = 1'b0;
    checkOutput("same_done", 32'(done), 32'd1);
`ifdef JUMP_TABLE_BYPASS_EN
    checkOutput("same_hit", 32'(lk_hit), 32'd1);
    checkOutput("same_target", 32'(lk_target), 32'd33);
`else
    checkOutput("same_hit", 32'(lk_hit), 32'd0);
    checkOutput("same_target", 32'(lk_target), 32'd0);
`endif
    applyStimulus();
    lk_req = 1'b0;
    checkOutput("same_next_hit", 32'(lk_hit), 32'd1);
    checkOutput("same_next_target", 32'(lk_target), 32'd33);

    $display("[TB] count zero load");
    ld_start = 1'b1; ld_base = 6'd20; ld_count = 7'd0;
    applyStimulus();
    ld_start = 1'b0;
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    applyStimulus();
    checkOutput("zero_done_once", 32'(done), 32'd0);

    $display("[TB] reset mid-load");
    ld_start = 1'b1; ld_base = 6'd40; ld_count = 7'd4;
    applyStimulus();
    ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 6'd1;
    applyStimulus();
    ld_data = 6'd2;
    applyStimulus();
    ld_data = 6'd3;
    reset = 1'b1;
    #1;
    checkOutput("rstmid_ready", 32'(ld_ready), 32'd0);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    applyStimulus();
    ld_valid = 1'b0;
    reset = 1'b0;
    done_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      if (done) done_pulses++;
    end
    checkOutput("rstmid_no_done", 32'(done_pulses), 32'd0);
    lookupCheck("rstmid_e40", 6'd40, 1'b0, 6'd0);
    lookupCheck("rstmid_e41", 6'd41, 1'b0, 6'd0);
    lookupCheck("rstmid_e7", 6'd7, 1'b0, 6'd0);

    $display("[TB] clear and load together");
    clr_start = 1'b1; ld_start = 1'b1; ld_base = 6'd0; ld_count = 7'd2;
    applyStimulus();
    clr_start = 1'b0; ld_start = 1'b0;
    checkOutput("both_busy", 32'(busy), 32'd1);
    checkOutput("both_ready", 32'(ld_ready), 32'd0);
    ld_valid = 1'b1; ld_data = 6'd9;
    busy_cycles = 0;
    done_pulses = 0;
    for (int i = 0; i < 80; i++) begin
      if (busy) busy_cycles++;
      if (done) done_pulses++;
      applyStimulus();
    end
    ld_valid = 1'b0;
    checkOutput("both_busy_cycles", 32'(busy_cycles), 32'd64);
    checkOutput("both_done_pulses", 32'(done_pulses), 32'd1);
    lookupCheck("both_e0", 6'd0, 1'b0, 6'd0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
